// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory bus arbiter and its helpers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Select a winner from the request pair
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one valid/ready memory bus between the load/store port (0) and the
// prefetch port (1), one transaction at a time, with a hung-bus watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant
);

  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 32'd1);
  localparam logic [CW-1:0] WDOG_MAX  = {CW{1'b1}};

  state_e        state_r;
  logic          last_r;
  logic [CW-1:0] wdog_r;
  logic          pick_valid_s;
  logic          pick_id_s;
  logic [31:0]   sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic [3:0]    sel_wstrb_s;

  rr_pick2 u_pick (
    .req       ({m1_valid, m0_valid}),
    .last      (last_r),
    .gnt_valid (pick_valid_s),
    .gnt_id    (pick_id_s)
  );

  // Route the winning requester's payload toward the bus registers
  always_comb begin
    if (pick_id_s) begin
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
      sel_wstrb_s = m1_wstrb;
    end else begin
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_wstrb_s = m0_wstrb;
    end
  end

  // Arbitration FSM; every output is registered here
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      m0_ready  <= 1'b0;
      m0_rdata  <= 32'd0;
      m0_err    <= 1'b0;
      m1_ready  <= 1'b0;
      m1_rdata  <= 32'd0;
      m1_err    <= 1'b0;
      busy      <= 1'b0;
      grant     <= 1'b0;
      last_r    <= 1'b1;
      wdog_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            mem_valid <= 1'b1;
            mem_addr  <= sel_addr_s;
            mem_wdata <= sel_wdata_s;
            mem_wstrb <= sel_wstrb_s;
            grant     <= pick_id_s;
            last_r    <= pick_id_s;
            wdog_r    <= '0;
            busy      <= 1'b1;
            state_r   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A real completion beats a watchdog expiry in the same cycle
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'd0;
            state_r   <= ST_DONE;
            if (grant) begin
              m1_ready <= 1'b1;
              m1_rdata <= mem_rdata;
              m1_err   <= 1'b0;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= mem_rdata;
              m0_err   <= 1'b0;
            end
          end else if ((TIMEOUT != 32'd0) && (wdog_r == WDOG_LAST)) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'd0;
            state_r   <= ST_DONE;
            if (grant) begin
              m1_ready <= 1'b1;
              m1_rdata <= TIMEOUT_FILL;
              m1_err   <= 1'b1;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= TIMEOUT_FILL;
              m0_err   <= 1'b1;
            end
          end else if (wdog_r != WDOG_MAX) begin
            wdog_r <= wdog_r + CW'(1);
          end
        end
        ST_DONE: begin
          // Gap cycle: lets the requester drop or replace valid after ready
          m0_ready <= 1'b0;
          m0_err   <= 1'b0;
          m1_ready <= 1'b0;
          m1_err   <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          mem_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (watchdog instance TIMEOUT=4
// plus a TIMEOUT=0 instance for the disabled-watchdog case).
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        m0_valid, m1_valid, m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, mem_wstrb;
  logic        mem_valid, mem_ready, busy, grant;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        w0_valid, w1_valid, w0_ready, w1_ready, w0_err, w1_err;
  logic [31:0] w0_rdata, w1_rdata, w_mem_addr, w_mem_wdata;
  logic [3:0]  w_mem_wstrb;
  logic        w_mem_valid, w_mem_ready, w_busy, w_grant;

  mem_bus_arbiter #(.TIMEOUT(4), .CW(8)) u_dut (
    .clk(clk), .rstn(rstn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .busy(busy), .grant(grant)
  );

  mem_bus_arbiter #(.TIMEOUT(0), .CW(8)) u_dut_nowd (
    .clk(clk), .rstn(rstn),
    .m0_valid(w0_valid), .m0_addr(32'h0000_0080), .m0_wdata(32'd0), .m0_wstrb(4'd0),
    .m0_ready(w0_ready), .m0_rdata(w0_rdata), .m0_err(w0_err),
    .m1_valid(w1_valid), .m1_addr(32'd0), .m1_wdata(32'd0), .m1_wstrb(4'd0),
    .m1_ready(w1_ready), .m1_rdata(w1_rdata), .m1_err(w1_err),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_wstrb(w_mem_wstrb), .mem_rdata(32'h7777_7777),
    .busy(w_busy), .grant(w_grant)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  initial begin
    int   prev;
    int   waited;
    logic exp_g;

    rstn = 1'b0;
    m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    w0_valid = 1'b0; w1_valid = 1'b0; w_mem_ready = 1'b0;
    cyc(); cyc();

    // Reset state
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'({m0_ready, m1_ready, m0_err, m1_err}), 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    rstn = 1'b1;

    // Single read on port 0, mem_ready two cycles after mem_valid
    m0_valid = 1'b1; m0_addr = 32'h0005_0000; m0_wstrb = 4'd0;
    cyc();
    check("rd_mem_valid", 32'(mem_valid), 32'd1);
    check("rd_mem_addr", mem_addr, 32'h0005_0000);
    check("rd_busy", 32'(busy), 32'd1);
    cyc();
    check("rd_hold", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    check("rd_m0_ready", 32'(m0_ready), 32'd1);
    check("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("rd_m0_err", 32'(m0_err), 32'd0);
    check("rd_mem_valid_drop", 32'(mem_valid), 32'd0);
    check("rd_m1_untouched", 32'(m1_ready), 32'd0);
    check("rd_m1_rdata", m1_rdata, 32'd0);
    mem_ready = 1'b0; m0_valid = 1'b0;
    cyc();
    check("rd_ready_pulse", 32'(m0_ready), 32'd0);
    check("rd_busy_done", 32'(busy), 32'd0);

    // Write on port 1
    m1_valid = 1'b1; m1_addr = 32'h10; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
    cyc();
    check("wr_grant", 32'(grant), 32'd1);
    check("wr_mem_wstrb", 32'(mem_wstrb), 32'h3);
    check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    cyc();
    check("wr_m1_ready", 32'(m1_ready), 32'd1);
    check("wr_m1_rdata", m1_rdata, 32'hA5A5_A5A5);
    check("wr_wstrb_clr", 32'(mem_wstrb), 32'd0);
    check("wr_m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
    mem_ready = 1'b0; m1_valid = 1'b0; m1_wstrb = 4'd0;
    cyc();

    // Round-robin under continuous ties after reset: grants 0,1,0,1 every 4 cycles
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h100; m1_valid = 1'b1; m1_addr = 32'h200;
    prev = 0;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2) == 1;
      waited = 0;
      while (!mem_valid && waited < 10) begin
        cyc();
        waited++;
      end
      check("rr_grant_seen", 32'(mem_valid), 32'd1);
      check("rr_grant", 32'(grant), 32'(exp_g));
      check("rr_addr", mem_addr, exp_g ? 32'h200 : 32'h100);
      if (t > 0) check("rr_gap", 32'(cyc_cnt - prev), 32'd4);
      prev = cyc_cnt;
      cyc();
      mem_ready = 1'b1; mem_rdata = 32'h5000_0000 + 32'(t);
      cyc();
      check("rr_ready", 32'(exp_g ? m1_ready : m0_ready), 32'd1);
      check("rr_other_quiet", 32'(exp_g ? m0_ready : m1_ready), 32'd0);
      mem_ready = 1'b0;
      if (t == 3) begin
        m0_valid = 1'b0; m1_valid = 1'b0;
      end
    end
    cyc();

    // Watchdog abort after 4 BUSY cycles, then a late mem_ready is ignored
    m0_valid = 1'b1; m0_addr = 32'h40;
    cyc();
    check("to_grant", 32'(grant), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      check("to_still_valid", 32'(mem_valid), 32'd1);
    end
    cyc();
    check("to_mem_valid", 32'(mem_valid), 32'd0);
    check("to_m0_ready", 32'(m0_ready), 32'd1);
    check("to_m0_err", 32'(m0_err), 32'd1);
    check("to_m0_rdata", m0_rdata, 32'hFFFF_FFFF);
    m0_valid = 1'b0;
    cyc();
    check("to_err_clr", 32'({m0_ready, m0_err}), 32'd0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    cyc();
    check("late_ready", 32'(m0_ready), 32'd0);
    check("late_rdata", m0_rdata, 32'hFFFF_FFFF);
    check("late_busy", 32'(busy), 32'd0);
    mem_ready = 1'b0;

    // mem_ready on the 4th BUSY cycle wins over the watchdog
    m0_valid = 1'b1; m0_addr = 32'h44;
    cyc();
    cyc(); cyc(); cyc();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    cyc();
    check("edge_ready", 32'(m0_ready), 32'd1);
    check("edge_err", 32'(m0_err), 32'd0);
    check("edge_rdata", m0_rdata, 32'hCAFE_F00D);
    mem_ready = 1'b0; m0_valid = 1'b0;
    cyc(); cyc();

    // Reset while BUSY drops the transaction; next tie goes to port 0
    m1_valid = 1'b1; m1_addr = 32'h300;
    cyc();
    check("mr_grant", 32'(grant), 32'd1);
    cyc();
    rstn = 1'b0;
    cyc();
    check("mr_mem_valid", 32'(mem_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_no_ready", 32'(m1_ready), 32'd0);
    rstn = 1'b1; m0_valid = 1'b1; m0_addr = 32'h400;
    cyc();
    check("mr_tie_grant", 32'(grant), 32'd0);
    check("mr_tie_addr", mem_addr, 32'h400);
    mem_ready = 1'b1; mem_rdata = 32'h2222_2222;
    cyc();
    check("mr_m0_ready", 32'(m0_ready), 32'd1);
    mem_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    cyc();

    // TIMEOUT=0: no abort even after 1000 cycles
    w0_valid = 1'b1;
    cyc();
    check("nowd_grant", 32'(w_mem_valid), 32'd1);
    repeat (1000) cyc();
    check("nowd_still_valid", 32'(w_mem_valid), 32'd1);
    check("nowd_no_ready", 32'(w0_ready), 32'd0);
    check("nowd_busy", 32'(w_busy), 32'd1);
    w_mem_ready = 1'b1;
    cyc();
    check("nowd_ready", 32'(w0_ready), 32'd1);
    check("nowd_err", 32'(w0_err), 32'd0);
    check("nowd_rdata", w0_rdata, 32'h7777_7777);
    w_mem_ready = 1'b0; w0_valid = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus (valid/ready, 32-bit addr/data, 4-bit wstrb) between two requesters.
- Port 0 is the data load/store path; port 1 is the instruction prefetch path.
- Uses round-robin arbitration, one outstanding transaction, and registered bus outputs.
- Has a watchdog that aborts a transaction when mem_ready never arrives, so a hung bus cannot deadlock the microcode engine.

Parameters:
- TIMEOUT, 255, max cycles in BUSY before abort; 0 disables the watchdog.
- CW, 8, width of the watchdog counter; must satisfy TIMEOUT < 2**CW.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: synchronous, active-low.
- mX_valid  in  1  request from port X (X=0,1); held with its payload until mX_ready.
- mX_addr  in  32  request address.
- mX_wdata  in  32  write data.
- mX_wstrb  in  4  byte strobes; 0 means read.
- mX_ready  out  1  one-cycle completion pulse.
- mX_rdata  out  32  read data; valid while mX_ready=1.
- mX_err  out  1  high with mX_ready when the transaction timed out.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus completion.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_wstrb  out  4  bus strobes.
- mem_rdata  in  32  bus read data.
- busy  out  1  high while state is not IDLE.
- grant  out  1  id of the port owning the current or last transaction.

Behaviour:
- Reset values (all synchronous on rstn=0; reset mid-transaction drops it silently, no ready pulse):
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - mX_ready=0, mX_rdata=0, mX_err=0.
  - busy=0, grant=0, last=1, wdog=0.
  - state=IDLE.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the port != last. After reset, last=1, so port 0 wins the first tie.
  - On grant, at the same edge: latch addr/wdata/wstrb into mem_*, set mem_valid<=1, grant<=X, last<=X, wdog<=0, state<=BUSY.
  - Latency: the request is sampled at edge E and mem_valid is high after E.
- BUSY:
  - mem_* are held stable.
  - mem_ready=1: mem_valid<=0, mem_wstrb<=0, mX_rdata<=mem_rdata (also captured on writes), mX_ready<=1, mX_err<=0, state<=DONE.
  - Otherwise, if TIMEOUT!=0 and wdog==TIMEOUT-1: mem_valid<=0, mem_wstrb<=0, mX_rdata<=32'hFFFFFFFF, mX_ready<=1, mX_err<=1, state<=DONE.
  - Otherwise wdog<=wdog+1. The counter saturates and never wraps.
  - mem_ready and timeout in the same cycle: mem_ready wins, no error.
- DONE:
  - mX_ready<=0 and mX_err<=0; state<=IDLE.
  - No grant is issued in DONE. This gap cycle lets the requester drop or replace its valid after seeing ready.
  - Back-to-back throughput is therefore one transaction per 3 cycles plus bus latency.
- mem_ready while not BUSY (stray or late after a timeout) is ignored. No output changes.
- A requester dropping valid while granted is a protocol violation. The transaction still completes on the latched payload and the ready pulse is still issued.
- Only the granted port's ready/rdata/err change. The other port's rdata holds its last value.
- grant and last update only on a new grant.

Decomposition:
- Shared package mem_bus_pkg holds the state encodings (ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2) and the timeout fill word 32'hFFFFFFFF.
- One natural sub-module: rr_pick2. It is combinational: inputs req[1:0] and last, outputs gnt_valid and gnt_id. It is reused by a later register-file port arbiter.
- Everything else is inline.

Test Plan:
- Single read on port 0: m0 addr=0x00050000, wstrb=0; bus answers mem_ready with rdata=0xDEADBEEF 2 cycles after mem_valid.
  -> mem_addr=0x00050000, then m0_ready pulses 1 cycle with m0_rdata=0xDEADBEEF, m0_err=0; m1 untouched.
- Simultaneous requests after reset: m0 and m1 both valid, each re-requesting immediately after its ready.
  -> grants go 0,1,0,1; each grant starts exactly 3 cycles plus bus latency after the previous one.
- Write on port 1: addr=0x10, wdata=0x12345678, wstrb=4'b0011.
  -> mem_wstrb=0011 and mem_wdata=0x12345678 while BUSY; mem_wstrb=0 after ready; m1_ready pulses.
- Timeout with TIMEOUT=4: mem_ready held 0.
  -> mem_valid drops after 4 BUSY cycles; m0_ready=1, m0_err=1, m0_rdata=0xFFFFFFFF; a late mem_ready 3 cycles later is ignored.
- mem_ready arrives exactly on timeout cycle 4 -> normal completion with err=0. Also check TIMEOUT=0: no abort after 1000 cycles.
- Reset mid-BUSY -> next cycle mem_valid=0, busy=0, no ready pulse; next tie goes to port 0.
